// File: rtl/data_bus_reg_slave.sv
// DATA_BUS responder: terminates req/gnt/rvalid transactions into a bank of
// 32-bit memory-mapped registers (software R/W or hardware-driven read-only).
// One transaction outstanding at a time, grant delayed by WAIT_STATES cycles.
module data_bus_reg_slave #(
    parameter logic [31:0]            BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned            NUM_REGS    = 8,
    parameter int unsigned            WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
    parameter logic [NUM_REGS*32-1:0] RESET_VAL   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic [31:0]              addr,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [31:0]              wdata,
    output logic                     gnt,
    output logic                     rvalid,
    output logic                     err,
    output logic [31:0]              rdata,
    output logic [NUM_REGS*32-1:0]   reg_q,
    input  logic [NUM_REGS*32-1:0]   hw_in,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] SPAN  = 32'(NUM_REGS * 4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    accept;

    logic [31:0]             off;
    logic                    aligned;
    logic                    in_range;
    logic [NUM_REGS-1:0]     hit;
    logic                    ro_hit;
    logic [31:0]             rd_word;
    logic                    dec_err;
    logic                    wr_ok;
    logic [NUM_REGS-1:0]     wr_sel;

    logic [NUM_REGS*32-1:0]  reg_r;

    // State and wait-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
        end
    end

    // Next-state and grant decision; a dropped req in WAIT abandons the request
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        accept    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        accept    = 1'b1;
                        state_nxt = S_RESP;
                    end else begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else if (cnt_r == CNT_W'(WAIT_STATES)) begin
                    accept    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
        if (rst) begin
            accept = 1'b0;
        end
    end

    assign gnt = accept;

    // Address decode: offset from base, one-hot register hit and read mux
    always_comb begin
        off      = addr - BASE_ADDR;
        aligned  = (off[1:0] == 2'b00);
        in_range = (off < SPAN);
        hit      = '0;
        rd_word  = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            hit[i] = in_range && (off[31:2] == 30'(i));
            if (hit[i]) begin
                rd_word = RO_MASK[i] ? hw_in[32*i +: 32] : reg_r[32*i +: 32];
            end
        end
        ro_hit  = |(hit & RO_MASK);
        dec_err = !aligned || !in_range || (we && ro_hit);
        wr_ok   = accept && we && !dec_err;
        wr_sel  = wr_ok ? hit : '0;
    end

    // Register bank with byte-enable writes; RO slots are held at zero
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (rst) begin
                reg_r[32*i +: 32] <= RO_MASK[i] ? 32'h0 : RESET_VAL[32*i +: 32];
            end else if (wr_sel[i] && !RO_MASK[i]) begin
                for (int j = 0; j < 4; j++) begin
                    if (be[j]) begin
                        reg_r[32*i + 8*j +: 8] <= wdata[8*j +: 8];
                    end
                end
            end
        end
    end

    assign reg_q = reg_r;

    // Response registered at accept: one-cycle rvalid with err/rdata and write strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid   <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            wr_pulse <= '0;
        end else begin
            rvalid   <= accept;
            err      <= accept && dec_err;
            rdata    <= (accept && !dec_err && !we) ? rd_word : 32'h0;
            wr_pulse <= wr_sel;
        end
    end

endmodule

// File: tb/tb_data_bus_reg_slave.sv
// Randomized self-checking bench for data_bus_reg_slave with a transaction-level model.
// Three instances share the bus inputs: wait states 0, 3 and 2.
module tb_data_bus_reg_slave;

    localparam logic [31:0]  BASE = 32'h4000_0000;
    localparam int unsigned  NR   = 8;
    localparam logic [7:0]   RO   = 8'h80;
    localparam logic [255:0] RV   = {32'h7700_0007, 32'h6600_0006, 32'h5500_0005, 32'h4400_0004,
                                     32'h3300_0003, 32'h2200_0002, 32'h1100_0001, 32'h0A0B_0C0D};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic         we;
    logic [3:0]   be;
    logic [31:0]  wdata;
    logic [255:0] hw_in;

    logic         req      [3];
    logic         gnt      [3];
    logic         rvalid   [3];
    logic         err      [3];
    logic [31:0]  rdata    [3];
    logic [255:0] reg_q    [3];
    logic [7:0]   wr_pulse [3];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            localparam int unsigned WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
            data_bus_reg_slave #(
                .BASE_ADDR  (BASE),
                .NUM_REGS   (NR),
                .WAIT_STATES(WS),
                .RO_MASK    (RO),
                .RESET_VAL  (RV)
            ) u_dut (
                .clk     (clk),
                .rst     (rst),
                .req     (req[g]),
                .addr    (addr),
                .we      (we),
                .be      (be),
                .wdata   (wdata),
                .gnt     (gnt[g]),
                .rvalid  (rvalid[g]),
                .err     (err[g]),
                .rdata   (rdata[g]),
                .reg_q   (reg_q[g]),
                .hw_in   (hw_in),
                .wr_pulse(wr_pulse[g])
            );
        end
    endgenerate

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m [3][8];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    task automatic reset_model();
        logic [255:0] rv_v;
        logic [7:0]   ro_v;
        rv_v = RV;
        ro_v = RO;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 8; i++)
                m[d][i] = ro_v[i] ? 32'h0 : rv_v[32*i +: 32];
    endtask

    function automatic logic [255:0] exp_q(input int d);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = m[d][i];
        return v;
    endfunction

    task automatic rand_hw();
        for (int i = 0; i < 8; i++) hw_in[32*i +: 32] = $urandom;
    endtask

    // One complete transaction on instance d; entered and left at a negedge
    task automatic txn(input int d, input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] wd, output logic [31:0] o_rdata, output logic o_err);
        logic        e_err;
        logic [31:0] e_rd;
        logic [7:0]  e_wp;
        logic [31:0] off;
        logic [7:0]  ro_v;
        int          n;
        int          idx;
        ro_v  = RO;
        addr  = a;
        we    = w;
        be    = b;
        wdata = wd;
        req[d] = 1'b1;
        n = 0;
        #1;
        while (gnt[d] !== 1'b1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("gnt_latency", 256'(n), 256'(ws_of(d)));
        if (n >= 40) begin
            req[d]  = 1'b0;
            o_rdata = '0;
            o_err   = 1'b0;
            @(negedge clk);
            return;
        end
        off  = a - BASE;
        e_err = 1'b0;
        e_rd  = 32'h0;
        e_wp  = 8'h0;
        idx   = int'(off[4:2]);
        if (a[1:0] != 2'b00 || off >= 32'd32 || (w && ro_v[idx])) begin
            e_err = 1'b1;
        end else if (w) begin
            for (int j = 0; j < 4; j++)
                if (b[j]) m[d][idx][8*j +: 8] = wd[8*j +: 8];
            e_wp[idx] = 1'b1;
        end else begin
            e_rd = ro_v[idx] ? hw_in[32*idx +: 32] : m[d][idx];
        end
        @(posedge clk);
        #1;
        req[d] = 1'b0;
        rand_hw();
        @(negedge clk);
        check("rvalid", 256'(rvalid[d]), 256'(1'b1));
        check("err", 256'(err[d]), 256'(e_err));
        check("rdata", 256'(rdata[d]), 256'(e_rd));
        check("wr_pulse", 256'(wr_pulse[d]), 256'(e_wp));
        check("reg_q", reg_q[d], exp_q(d));
        o_rdata = rdata[d];
        o_err   = err[d];
        @(negedge clk);
        check("rvalid_drop", 256'(rvalid[d]), 256'(1'b0));
        check("wr_pulse_drop", 256'(wr_pulse[d]), 256'(8'h0));
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        logic [7:0]  gv;
        logic [7:0]  rv;
        logic        seen;
        logic [31:0] a;
        int          d;

        rst   = 1'b1;
        addr  = BASE;
        we    = 1'b0;
        be    = 4'hF;
        wdata = '0;
        hw_in = '0;
        for (int k = 0; k < 3; k++) req[k] = 1'b0;
        req[0] = 1'b1;
        reset_model();
        repeat (2) @(negedge clk);
        #1;
        check("gnt_in_reset", 256'(gnt[0]), 256'(1'b0));
        for (int k = 0; k < 3; k++) begin
            check("rst_rvalid", 256'(rvalid[k]), 256'(1'b0));
            check("rst_err", 256'(err[k]), 256'(1'b0));
            check("rst_rdata", 256'(rdata[k]), 256'(32'h0));
            check("rst_wr_pulse", 256'(wr_pulse[k]), 256'(8'h0));
            check("rst_reg_q", reg_q[k], exp_q(k));
        end
        req[0] = 1'b0;
        rst    = 1'b0;
        @(negedge clk);

        // Basic write then read-back, zero wait states
        txn(0, BASE + 32'h4, 1'b1, 4'hF, 32'hDEAD_BEEF, r, e);
        check("t1_reg1", 256'(reg_q[0][63:32]), 256'(32'hDEAD_BEEF));
        txn(0, BASE + 32'h4, 1'b0, 4'h0, 32'h0, r, e);
        check("t1_readback", 256'(r), 256'(32'hDEAD_BEEF));

        // Partial byte enables
        txn(0, BASE + 32'h4, 1'b1, 4'b0101, 32'h1122_3344, r, e);
        check("t2_reg1", 256'(reg_q[0][63:32]), 256'(32'hDE22_BE44));

        // Decode errors
        txn(0, BASE + 32'h20, 1'b0, 4'hF, 32'h0, r, e);
        check("t3_oob_err", 256'(e), 256'(1'b1));
        check("t3_oob_rdata", 256'(r), 256'(32'h0));
        txn(0, BASE + 32'h2, 1'b1, 4'hF, 32'h5555_AAAA, r, e);
        check("t3_misalign_err", 256'(e), 256'(1'b1));
        txn(0, 32'h3FFF_FFFC, 1'b1, 4'hF, 32'h1234_5678, r, e);
        check("t3_below_base_err", 256'(e), 256'(1'b1));

        // Read-only register sourced from hw_in
        hw_in[255:224] = 32'hCAFE_0007;
        txn(0, BASE + 32'h1C, 1'b0, 4'hF, 32'h0, r, e);
        check("t4_ro_rdata", 256'(r), 256'(32'hCAFE_0007));
        check("t4_ro_err", 256'(e), 256'(1'b0));
        txn(0, BASE + 32'h1C, 1'b1, 4'hF, 32'hFFFF_FFFF, r, e);
        check("t4_ro_write_err", 256'(e), 256'(1'b1));

        // Two wait states with req held high continuously
        addr = BASE;
        we   = 1'b0;
        be   = 4'hF;
        req[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            gv[c] = gnt[2];
            rv[c] = rvalid[2];
            @(negedge clk);
        end
        req[2] = 1'b0;
        check("t5_gnt_cycles", 256'(gv), 256'(8'b0100_0100));
        check("t5_rvalid_cycles", 256'(rv), 256'(8'b1000_1000));
        @(negedge clk);

        // Reset while waiting for grant (three wait states)
        txn(1, BASE + 32'h8, 1'b1, 4'hF, 32'h0BAD_F00D, r, e);
        addr = BASE + 32'hC;
        we   = 1'b1;
        wdata = 32'h1357_9BDF;
        req[1] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("t6_no_gnt_in_wait", 256'(gnt[1]), 256'(1'b0));
        rst    = 1'b1;
        req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            seen = seen | rvalid[1] | gnt[1];
            @(negedge clk);
        end
        check("t6_rst_no_resp", 256'(seen), 256'(1'b0));
        check("t6_rst_reg_q", reg_q[1], exp_q(1));

        // req dropped during WAIT abandons the request
        addr   = BASE + 32'h10;
        req[1] = 1'b1;
        repeat (2) @(negedge clk);
        req[1] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            seen = seen | rvalid[1] | gnt[1];
            @(negedge clk);
        end
        check("t6_drop_no_resp", 256'(seen), 256'(1'b0));
        check("t6_drop_reg_q", reg_q[1], exp_q(1));
        txn(1, BASE + 32'h10, 1'b1, 4'hF, 32'h2468_ACE0, r, e);

        // Randomized traffic across all three instances
        for (int k = 0; k < 150; k++) begin
            d = $urandom_range(0, 2);
            case ($urandom_range(0, 9))
                7:       a = BASE + 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
                8:       a = BASE + 32'h20 + 32'($urandom_range(0, 1000) * 4);
                9:       a = BASE - 32'($urandom_range(1, 8) * 4);
                default: a = BASE + 32'($urandom_range(0, 7) * 4);
            endcase
            rand_hw();
            txn(d, a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, r, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
